pixel_block_packer: RTL and testbench

//   Upstream stage of the Nios compression handler. Collects a raster stream of 8-bit

---
 rtl/pixel_block_packer.sv | 158 +++++++++++++++
 tb/tb_pixel_block_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_block_packer.sv
// pixel_block_packer
//   Collects a raster stream of 8-bit pixels into 8x8 blocks and presents each
//   completed block as sixteen 32-bit line words on one flat bus with a
//   valid/ack handshake. Two ping-pong banks let the next block fill while the
//   current one waits for its ack.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   pix_valid  in   pixel strobe
//   pix_data   in   pixel value (raster order within block)
//   pix_sof    in   first pixel of a block (resync), qualified by pix_valid
//   pix_ready  out  a pixel is accepted this cycle (registers only)
//   blk_valid  out  blk_data holds a complete block
//   blk_data   out  word k at [32k+31:32k]; k=0 Line1_1 ... k=15 Line8_2
//   blk_ack    in   consumer takes the block (only while blk_valid)
//   blk_count  out  blocks acknowledged, wraps
//   drop_count out  partial blocks discarded by pix_sof, saturates at 255

// One pixel bank. Pixel n lands in word n/PPW with the first pixel of each
// word in the MSB byte, so the byte slot is the index with its low bits
// inverted.
module pbp_bank #(
  parameter int PIX_W   = 8,
  parameter int BLK_PIX = 64,
  parameter int WORD_W  = 32,
  parameter int IDX_W   = $clog2(BLK_PIX)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [PIX_W-1:0]         wr_pix_i,
  output logic [BLK_PIX*PIX_W-1:0] data_o
);
  localparam int SH = $clog2(WORD_W / PIX_W);

  logic [BLK_PIX-1:0][PIX_W-1:0] bytes_q;
  logic [IDX_W-1:0]              slot;

  assign slot = {wr_idx_i[IDX_W-1:SH], ~wr_idx_i[SH-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       bytes_q       <= '0;
    else if (wr_en_i) bytes_q[slot] <= wr_pix_i;
  end

  assign data_o = bytes_q;
endmodule

module pixel_block_packer #(
  parameter int PIX_W   = 8,
  parameter int BLK_PIX = 64,
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic [PIX_W-1:0]         pix_data,
  input  logic                     pix_sof,
  output logic                     pix_ready,
  output logic                     blk_valid,
  output logic [BLK_PIX*PIX_W-1:0] blk_data,
  input  logic                     blk_ack,
  output logic [CNT_W-1:0]         blk_count,
  output logic [7:0]               drop_count
);
  localparam int IDX_W = $clog2(BLK_PIX);
  localparam int DW    = BLK_PIX * PIX_W;

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic [7:0]       drop_q, drop_d;

  logic             acc, ack, done;
  logic [IDX_W-1:0] wpos;
  logic [1:0][DW-1:0] bank_data;

  assign pix_ready = !full_q[wr_sel_q];
  assign acc       = pix_valid && pix_ready;
  assign ack       = full_q[rd_sel_q] && blk_ack;
  // An sof pixel always lands at slot 0, so it can never complete a bank.
  assign wpos      = pix_sof ? '0 : idx_q;
  assign done      = acc && !pix_sof && (idx_q == IDX_W'(BLK_PIX - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pbp_bank #(
      .PIX_W  (PIX_W),
      .BLK_PIX(BLK_PIX),
      .WORD_W (WORD_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en_i (acc && (wr_sel_q == 1'(b))),
      .wr_idx_i(wpos),
      .wr_pix_i(pix_data),
      .data_o  (bank_data[b])
    );
  end

  always_comb begin
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    idx_d       = idx_q;
    blk_count_d = blk_count_q;
    drop_d      = drop_q;

    // Ack and completion always hit different banks (the write bank is
    // empty, the read bank is full), so both updates can apply together.
    if (ack) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      blk_count_d      = blk_count_q + 1'b1;
    end

    if (acc) begin
      if (pix_sof) begin
        idx_d = IDX_W'(1);
        if (idx_q != '0 && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else if (done) begin
        idx_d            = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= '0;
      idx_q       <= '0;
      blk_count_q <= '0;
      drop_q      <= '0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
      idx_q       <= idx_d;
      blk_count_q <= blk_count_d;
      drop_q      <= drop_d;
    end
  end

  assign blk_valid  = full_q[rd_sel_q];
  assign blk_data   = bank_data[rd_sel_q];
  assign blk_count  = blk_count_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_pixel_block_packer.sv
module tb_pixel_block_packer;
  logic         clk = 1'b0;
  logic         reset;
  logic         pix_valid, pix_sof, blk_ack;
  logic [7:0]   pix_data;
  logic         pix_ready, blk_valid;
  logic [511:0] blk_data;
  logic [15:0]  blk_count;
  logic [7:0]   drop_count;

  pixel_block_packer dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ack   (blk_ack),
    .blk_count (blk_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  stp;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  function automatic logic [31:0] word(input int k);
    return blk_data[32*k +: 32];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel until it is accepted; pix_ready is register-driven, so
  // the value seen just after an edge holds for the coming edge.
  task automatic put_pix(input logic [7:0] d, input logic sof);
    bit took;
    int guard;
    guard = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    do begin
      took = pix_ready;
      step();
      guard++;
    end while (!took && guard < 300);
    if (!took) chk("put_pix_timeout", 32'd0, 32'd1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic stream(input logic [7:0] base, input logic [7:0] stp, input int n);
    for (int i = 0; i < n; i++) put_pix(8'(base + stp * 8'(i)), 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h01, 32'h00010203, 32'h3C3D3E3F};
    vecs[1] = '{8'h80, 8'h01, 32'h80818283, 32'hBCBDBEBF};
    vecs[2] = '{8'hFF, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[3] = '{8'h10, 8'h02, 32'h10121416, 32'h888A8C8E};
    vecs[4] = '{8'hF0, 8'h03, 32'hF0F3F6F9, 32'hA4A7AAAD};

    reset = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; blk_ack = 1'b0;
    #2;
    chk("rst_blk_valid", 32'(blk_valid), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_w0", word(0), 32'd0);
    chk("rst_w15", word(15), 32'd0);
    chk("rst_blk_count", 32'(blk_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Table: full blocks with ack held high.
    blk_ack = 1'b1;
    for (int v = 0; v < 5; v++) begin
      stream(vecs[v].base, vecs[v].stp, 63);
      chk("tbl_pre_valid", 32'(blk_valid), 32'd0);
      put_pix(8'(vecs[v].base + vecs[v].stp * 8'd63), 1'b0);
      chk("tbl_valid", 32'(blk_valid), 32'd1);
      chk("tbl_w0", word(0), vecs[v].w0);
      chk("tbl_w15", word(15), vecs[v].w15);
      step();
      exp_cnt++;
      chk("tbl_count", 32'(blk_count), 32'(exp_cnt));
      chk("tbl_drained", 32'(blk_valid), 32'd0);
    end

    // Back-pressure: both banks fill, source must wait.
    blk_ack = 1'b0;
    stream(8'h00, 8'h01, 128);
    chk("bp_ready_low", 32'(pix_ready), 32'd0);
    chk("bp_valid", 32'(blk_valid), 32'd1);
    chk("bp_w0", word(0), 32'h00010203);
    pix_valid = 1'b1; pix_data = 8'hEE;
    repeat (3) step();
    chk("bp_hold_ready", 32'(pix_ready), 32'd0);
    chk("bp_hold_w0", word(0), 32'h00010203);
    chk("bp_hold_w15", word(15), 32'h3C3D3E3F);
    pix_valid = 1'b0;
    blk_ack = 1'b1; step(); blk_ack = 1'b0;
    exp_cnt++;
    chk("bp_next_w0", word(0), 32'h40414243);
    chk("bp_next_w15", word(15), 32'h7C7D7E7F);
    chk("bp_ready_back", 32'(pix_ready), 32'd1);
    chk("bp_next_valid", 32'(blk_valid), 32'd1);
    chk("bp_count", 32'(blk_count), 32'(exp_cnt));
    step();
    chk("bp_no_ack_hold", 32'(blk_valid), 32'd1);
    blk_ack = 1'b1; step(); blk_ack = 1'b0;
    exp_cnt++;
    chk("bp_empty", 32'(blk_valid), 32'd0);
    blk_ack = 1'b1; step(); blk_ack = 1'b0;
    chk("ack_idle_ignored", 32'(blk_count), 32'(exp_cnt));

    // Resync drop, then sof at idx 0 (no drop).
    blk_ack = 1'b1;
    stream(8'h00, 8'h01, 10);
    put_pix(8'hAA, 1'b1);
    stream(8'h11, 8'h00, 63);
    chk("sof_drop", 32'(drop_count), 32'd1);
    chk("sof_valid", 32'(blk_valid), 32'd1);
    chk("sof_w0", word(0), 32'hAA111111);
    chk("sof_w15", word(15), 32'h11111111);
    step();
    exp_cnt++;
    put_pix(8'h5A, 1'b1);
    stream(8'h22, 8'h00, 63);
    chk("sof0_no_drop", 32'(drop_count), 32'd1);
    chk("sof0_w0", word(0), 32'h5A222222);
    step();
    exp_cnt++;
    chk("sof_count", 32'(blk_count), 32'(exp_cnt));

    // Completion of block B on the same edge as the ack of block A.
    blk_ack = 1'b0;
    stream(8'h20, 8'h01, 64);
    chk("sim_a_w0", word(0), 32'h20212223);
    stream(8'h50, 8'h01, 63);
    blk_ack = 1'b1;
    put_pix(8'h8F, 1'b0);
    blk_ack = 1'b0;
    exp_cnt++;
    chk("sim_valid", 32'(blk_valid), 32'd1);
    chk("sim_b_w0", word(0), 32'h50515253);
    chk("sim_b_w15", word(15), 32'h8C8D8E8F);
    chk("sim_count", 32'(blk_count), 32'(exp_cnt));
    blk_ack = 1'b1; step(); blk_ack = 1'b0;
    exp_cnt++;
    chk("sim_drained", 32'(blk_valid), 32'd0);

    // Async reset mid-operation with a pending block and a partial one.
    stream(8'h33, 8'h00, 64);
    stream(8'h77, 8'h00, 30);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(blk_valid), 32'd0);
    chk("mid_rst_ready", 32'(pix_ready), 32'd1);
    chk("mid_rst_w0", word(0), 32'd0);
    chk("mid_rst_count", 32'(blk_count), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    step();
    reset = 1'b1;
    exp_cnt = 0;
    blk_ack = 1'b1;
    stream(8'h00, 8'h01, 64);
    chk("post_rst_valid", 32'(blk_valid), 32'd1);
    chk("post_rst_w0", word(0), 32'h00010203);
    chk("post_rst_w15", word(15), 32'h3C3D3E3F);
    step();
    exp_cnt++;
    chk("post_rst_count", 32'(blk_count), 32'(exp_cnt));
    chk("post_rst_drop", 32'(drop_count), 32'd0);
    blk_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
